// File: rtl/sim_memory_pkg.sv
// Shared definitions for the simulation memory arbiter: requester IDs, tag depth defaults,
// access-order encoding and the request record held in the output register.
package sim_memory_pkg;

    localparam int unsigned REQ_ID_W            = 1;
    localparam int unsigned TAG_DEPTH_DEFAULT   = 8;
    localparam int unsigned TAG_DEPTH_N_DEFAULT = 3;

    typedef enum logic [1:0] {
        OrderByte = 2'b00,
        OrderHalf = 2'b01,
        OrderWord = 2'b10,
        OrderNone = 2'b11
    } order_e;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

endpackage

// File: rtl/sim_memory_arbiter_if.sv
// Requester and memory-side bus of the simulation memory arbiter.
// slave: arbiter view; master: view of the requesters and memory model together.
interface sim_memory_arbiter_if;

    logic        iP0_REQ;
    logic [1:0]  iP0_ORDER;
    logic [3:0]  iP0_MASK;
    logic        iP0_RW;
    logic [31:0] iP0_ADDR;
    logic [31:0] iP0_DATA;
    logic        iP0_LOCK;
    logic        oP0_LOCK;
    logic        oP0_VALID;
    logic [63:0] oP0_DATA;

    logic        iP1_REQ;
    logic [1:0]  iP1_ORDER;
    logic [3:0]  iP1_MASK;
    logic        iP1_RW;
    logic [31:0] iP1_ADDR;
    logic [31:0] iP1_DATA;
    logic        iP1_LOCK;
    logic        oP1_LOCK;
    logic        oP1_VALID;
    logic [63:0] oP1_DATA;

    logic        oMEM_REQ;
    logic [1:0]  oMEM_ORDER;
    logic [3:0]  oMEM_MASK;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic        oMEM_LOCK;
    logic        iMEM_LOCK;
    logic        iMEM_VALID;
    logic [63:0] iMEM_DATA;

    modport slave (
        input  iP0_REQ, iP0_ORDER, iP0_MASK, iP0_RW, iP0_ADDR, iP0_DATA, iP0_LOCK,
        input  iP1_REQ, iP1_ORDER, iP1_MASK, iP1_RW, iP1_ADDR, iP1_DATA, iP1_LOCK,
        output oP0_LOCK, oP0_VALID, oP0_DATA, oP1_LOCK, oP1_VALID, oP1_DATA,
        output oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA, oMEM_LOCK,
        input  iMEM_LOCK, iMEM_VALID, iMEM_DATA
    );

    modport master (
        output iP0_REQ, iP0_ORDER, iP0_MASK, iP0_RW, iP0_ADDR, iP0_DATA, iP0_LOCK,
        output iP1_REQ, iP1_ORDER, iP1_MASK, iP1_RW, iP1_ADDR, iP1_DATA, iP1_LOCK,
        input  oP0_LOCK, oP0_VALID, oP0_DATA, oP1_LOCK, oP1_VALID, oP1_DATA,
        input  oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA, oMEM_LOCK,
        output iMEM_LOCK, iMEM_VALID, iMEM_DATA
    );

endinterface

// File: rtl/sim_memory_arbiter_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding read, oldest at the head.
// Pushes while full and pops while empty are ignored.
module sim_memory_arbiter_tag_fifo
    import sim_memory_pkg::*;
#(
    parameter int unsigned P_DEPTH   = TAG_DEPTH_DEFAULT,
    parameter int unsigned P_DEPTH_N = TAG_DEPTH_N_DEFAULT
) (
    input  logic               iCLOCK,
    input  logic               iRESET_SYNC,
    input  logic               iPUSH,
    input  req_id_t            iPUSH_DATA,
    input  logic               iPOP,
    output req_id_t            oHEAD,
    output logic [P_DEPTH_N:0] oCOUNT,
    output logic               oFULL,
    output logic               oEMPTY
);

    req_id_t              mem_q [P_DEPTH];
    logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_N:0]   count_q, count_d;
    logic                 do_push, do_pop;

    // Explicit wrap so a non-power-of-two depth still works.
    function automatic logic [P_DEPTH_N-1:0] next_ptr(input logic [P_DEPTH_N-1:0] ptr);
        return (ptr == P_DEPTH_N'(P_DEPTH - 1)) ? '0 : ptr + P_DEPTH_N'(1);
    endfunction

    assign oFULL   = (count_q == (P_DEPTH_N + 1)'(P_DEPTH));
    assign oEMPTY  = (count_q == '0);
    assign oCOUNT  = count_q;
    assign oHEAD   = mem_q[rd_ptr_q];
    assign do_push = iPUSH && !oFULL;
    assign do_pop  = iPOP && !oEMPTY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (P_DEPTH_N + 1)'(do_push) - (P_DEPTH_N + 1)'(do_pop);
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(P_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= iPUSH_DATA;
            end
        end
    end

endmodule

// File: rtl/sim_memory_arbiter.sv
// Two-port arbiter in front of the simulation memory model: one output register, in-order
// response routing via a tag FIFO. Define SIM_MEMORY_ARBITER_FIXED_PRIORITY_EN for P0 priority.
module sim_memory_arbiter
    import sim_memory_pkg::*;
#(
    parameter int unsigned P_TAG_DEPTH   = TAG_DEPTH_DEFAULT,
    parameter int unsigned P_TAG_DEPTH_N = TAG_DEPTH_N_DEFAULT
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    sim_memory_arbiter_if.slave  bus,
    output logic                 oERR
);

    mem_req_t               out_q, out_d;
    logic                   req_q, req_d;
    logic                   err_q, err_d;
    logic                   can_take;
    logic                   elig0, elig1;
    logic                   gnt0, gnt1;
    logic                   accept;
    mem_req_t               p0_req, p1_req, sel_req;
    logic                   tag_push, tag_pop;
    logic                   tag_full, tag_empty;
    req_id_t                tag_head;
    logic [P_TAG_DEPTH_N:0] tag_count;

    assign p0_req = '{order: bus.iP0_ORDER, mask: bus.iP0_MASK, rw: bus.iP0_RW,
                      addr: bus.iP0_ADDR, data: bus.iP0_DATA};
    assign p1_req = '{order: bus.iP1_ORDER, mask: bus.iP1_MASK, rw: bus.iP1_RW,
                      addr: bus.iP1_ADDR, data: bus.iP1_DATA};

    // Empty, or retiring this cycle.
    assign can_take = !req_q || !bus.iMEM_LOCK;
    assign elig0    = !iRESET_SYNC && bus.iP0_REQ && can_take && (bus.iP0_RW || !tag_full);
    assign elig1    = !iRESET_SYNC && bus.iP1_REQ && can_take && (bus.iP1_RW || !tag_full);

`ifdef SIM_MEMORY_ARBITER_FIXED_PRIORITY_EN
    assign gnt0 = elig0;
    assign gnt1 = elig1 && !elig0;
`else
    logic last_q;  // 1 when port 1 was granted most recently

    assign gnt0 = elig0 && (!elig1 || last_q);
    assign gnt1 = elig1 && (!elig0 || !last_q);

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            last_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_q <= gnt1;
        end
    end
`endif

    assign accept   = gnt0 || gnt1;
    assign sel_req  = gnt1 ? p1_req : p0_req;
    assign tag_push = accept && !sel_req.rw;
    assign tag_pop  = bus.iMEM_VALID;

    always_comb begin
        req_d = req_q;
        out_d = out_q;
        err_d = err_q;
        if (accept) begin
            req_d = 1'b1;
            out_d = sel_req;
        end else if (req_q && !bus.iMEM_LOCK) begin
            req_d = 1'b0;
        end
        if ((bus.iMEM_VALID && tag_empty) ||
            (tag_push && (tag_count == (P_TAG_DEPTH_N + 1)'(P_TAG_DEPTH)))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            req_q <= 1'b0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            req_q <= req_d;
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    sim_memory_arbiter_tag_fifo #(
        .P_DEPTH   (P_TAG_DEPTH),
        .P_DEPTH_N (P_TAG_DEPTH_N)
    ) u_tag_fifo (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iPUSH       (tag_push),
        .iPUSH_DATA  (req_id_t'(gnt1)),
        .iPOP        (tag_pop),
        .oHEAD       (tag_head),
        .oCOUNT      (tag_count),
        .oFULL       (tag_full),
        .oEMPTY      (tag_empty)
    );

    assign bus.oP0_LOCK   = !gnt0;
    assign bus.oP1_LOCK   = !gnt1;
    assign bus.oP0_VALID  = !iRESET_SYNC && bus.iMEM_VALID && !tag_empty && (tag_head == 1'b0);
    assign bus.oP1_VALID  = !iRESET_SYNC && bus.iMEM_VALID && !tag_empty && (tag_head == 1'b1);
    assign bus.oP0_DATA   = bus.iMEM_DATA;
    assign bus.oP1_DATA   = bus.iMEM_DATA;

    assign bus.oMEM_REQ   = req_q;
    assign bus.oMEM_ORDER = out_q.order;
    assign bus.oMEM_MASK  = out_q.mask;
    assign bus.oMEM_RW    = out_q.rw;
    assign bus.oMEM_ADDR  = out_q.addr;
    assign bus.oMEM_DATA  = out_q.data;
    // Memory may only return data when the head owner can take it.
    assign bus.oMEM_LOCK  = tag_empty ? 1'b1 : (tag_head[0] ? bus.iP1_LOCK : bus.iP0_LOCK);

    assign oERR = err_q;

endmodule

// File: tb/tb_sim_memory_arbiter.sv
// Directed bench for sim_memory_arbiter: stimulus pushes expected memory requests and responses
// into queues; a forked monitor pops and compares whenever the DUT presents one.
module tb_sim_memory_arbiter;

    logic iCLOCK;
    logic iRESET_SYNC;
    logic oERR;

    sim_memory_arbiter_if bus ();

    sim_memory_arbiter dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .bus         (bus),
        .oERR        (oERR)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    int n_cmp;
    int n_bad;
    logic [70:0] exp_mem [$];
    logic [65:0] exp_rsp [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Order and mask are derived from the address so every request carries distinct fields.
    function automatic logic [70:0] mk(input logic rw, input logic [31:0] addr,
                                       input logic [31:0] data);
        return {addr[3:2], addr[7:4], rw, addr, data};
    endfunction

    task automatic set_p0(input logic req, input logic rw, input logic [31:0] addr,
                          input logic [31:0] data);
        bus.iP0_REQ = req; bus.iP0_RW = rw; bus.iP0_ADDR = addr; bus.iP0_DATA = data;
        bus.iP0_ORDER = addr[3:2]; bus.iP0_MASK = addr[7:4];
    endtask

    task automatic set_p1(input logic req, input logic rw, input logic [31:0] addr,
                          input logic [31:0] data);
        bus.iP1_REQ = req; bus.iP1_RW = rw; bus.iP1_ADDR = addr; bus.iP1_DATA = data;
        bus.iP1_ORDER = addr[3:2]; bus.iP1_MASK = addr[7:4];
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic respond(input logic [63:0] data, input logic to_p1);
        bus.iMEM_VALID = 1'b1;
        bus.iMEM_DATA  = data;
        exp_rsp.push_back({!to_p1, to_p1, data});
        tick();
        bus.iMEM_VALID = 1'b0;
    endtask

    task automatic do_reset();
        iRESET_SYNC = 1'b1;
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0);
        bus.iP0_LOCK = 0; bus.iP1_LOCK = 0;
        bus.iMEM_LOCK = 0; bus.iMEM_VALID = 0; bus.iMEM_DATA = '0;
        repeat (2) tick();
        iRESET_SYNC = 1'b0;
    endtask

    initial begin
        logic [31:0] a0, a1;
        n_cmp = 0;
        n_bad = 0;

        fork
            forever begin
                @(negedge iCLOCK);
                if (!iRESET_SYNC) begin
                    if (bus.oMEM_REQ && !bus.iMEM_LOCK) begin
                        if (exp_mem.size() == 0) begin
                            check("mem_req_unexpected", {bus.oMEM_ADDR}, 128'h0 - 1);
                        end else begin
                            check("mem_req", {bus.oMEM_ORDER, bus.oMEM_MASK, bus.oMEM_RW,
                                              bus.oMEM_ADDR, bus.oMEM_DATA},
                                  exp_mem.pop_front());
                        end
                    end
                    if (bus.oP0_VALID || bus.oP1_VALID) begin
                        if (exp_rsp.size() == 0) begin
                            check("rsp_unexpected", {bus.oP0_VALID, bus.oP1_VALID}, 0);
                        end else begin
                            check("rsp", {bus.oP0_VALID, bus.oP1_VALID, bus.oP0_DATA},
                                  exp_rsp.pop_front());
                            check("rsp_data_p1", bus.oP1_DATA, bus.iMEM_DATA);
                        end
                    end
                end
            end
        join_none

        // Reset state, with P0 requesting during reset.
        do_reset();
        iRESET_SYNC = 1'b1;
        set_p0(1, 1, 32'h10, 32'h0);
        bus.iMEM_VALID = 1'b1;
        tick();
        check("rst_p0_lock", bus.oP0_LOCK, 1);
        check("rst_p1_lock", bus.oP1_LOCK, 1);
        check("rst_valid", {bus.oP0_VALID, bus.oP1_VALID}, 0);
        check("rst_mem_req", bus.oMEM_REQ, 0);
        check("rst_mem_fields", {bus.oMEM_ORDER, bus.oMEM_MASK, bus.oMEM_RW, bus.oMEM_ADDR,
                                 bus.oMEM_DATA}, 0);
        check("rst_mem_lock", bus.oMEM_LOCK, 1);
        check("rst_err", oERR, 0);
        bus.iMEM_VALID = 1'b0;
        set_p0(0, 0, 0, 0);
        tick();
        iRESET_SYNC = 1'b0;

        // Single P0 read.
        set_p0(1, 0, 32'h100, 32'h0);
        exp_mem.push_back(mk(0, 32'h100, 32'h0));
        #1;
        check("t1_p0_grant", bus.oP0_LOCK, 0);
        tick();
        set_p0(0, 0, 0, 0);
        check("t1_mem_req", bus.oMEM_REQ, 1);
        check("t1_mem_addr", bus.oMEM_ADDR, 32'h100);
        check("t1_mem_lock_head_p0", bus.oMEM_LOCK, 0);
        tick();
        check("t1_mem_req_retired", bus.oMEM_REQ, 0);
        respond(64'h1111_2222_3333_4444, 0);

        // Both ports writing every cycle.
        do_reset();
`ifdef SIM_MEMORY_ARBITER_FIXED_PRIORITY_EN
        exp_mem.push_back(mk(1, 32'h200, 32'h200 ^ 32'hABCD_0000));
        exp_mem.push_back(mk(1, 32'h201, 32'h201 ^ 32'hABCD_0000));
        exp_mem.push_back(mk(1, 32'h202, 32'h202 ^ 32'hABCD_0000));
        exp_mem.push_back(mk(1, 32'h203, 32'h203 ^ 32'hABCD_0000));
`else
        exp_mem.push_back(mk(1, 32'h200, 32'h200 ^ 32'hABCD_0000));
        exp_mem.push_back(mk(1, 32'h300, 32'h300 ^ 32'hABCD_0000));
        exp_mem.push_back(mk(1, 32'h201, 32'h201 ^ 32'hABCD_0000));
        exp_mem.push_back(mk(1, 32'h301, 32'h301 ^ 32'hABCD_0000));
`endif
        a0 = 32'h200;
        a1 = 32'h300;
        for (int k = 0; k < 4; k++) begin
            set_p0(1, 1, a0, a0 ^ 32'hABCD_0000);
            set_p1(1, 1, a1, a1 ^ 32'hABCD_0000);
            #1;
`ifdef SIM_MEMORY_ARBITER_FIXED_PRIORITY_EN
            check("t2_locks", {bus.oP0_LOCK, bus.oP1_LOCK}, 2'b01);
`else
            check("t2_locks", {bus.oP0_LOCK, bus.oP1_LOCK}, (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
            if (!bus.oP0_LOCK) a0 = a0 + 1;
            if (!bus.oP1_LOCK) a1 = a1 + 1;
            tick();
        end
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0);
        repeat (2) tick();

        // Nine reads against a held-off responder: eight fill the tag FIFO.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_p0(1, 0, 32'h400 + 32'(k * 16), 32'h0);
            exp_mem.push_back(mk(0, 32'h400 + 32'(k * 16), 32'h0));
            #1;
            check("t3_accept", bus.oP0_LOCK, 0);
            tick();
        end
        set_p0(1, 0, 32'h480, 32'h0);
        exp_mem.push_back(mk(0, 32'h480, 32'h0));
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t3_ninth_locked", bus.oP0_LOCK, 1);
            tick();
        end
        bus.iMEM_VALID = 1'b1;
        bus.iMEM_DATA  = 64'hAAAA_0000_0000_0000;
        exp_rsp.push_back({2'b10, 64'hAAAA_0000_0000_0000});
        #1;
        check("t3_locked_while_popping", bus.oP0_LOCK, 1);
        tick();
        bus.iMEM_VALID = 1'b0;
        #1;
        check("t3_ninth_accept", bus.oP0_LOCK, 0);
        tick();
        set_p0(0, 0, 0, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            respond(64'hB000 + 64'(k), 0);
        end
        #1;
        check("t3_drained", bus.oMEM_LOCK, 1);
        check("t3_no_err", oERR, 0);

        // P0 read, P1 read, P0 write: responses in order, write silent.
        set_p0(1, 0, 32'h500, 32'h0);
        exp_mem.push_back(mk(0, 32'h500, 32'h0));
        tick();
        set_p0(0, 0, 0, 0);
        set_p1(1, 0, 32'h600, 32'h0);
        exp_mem.push_back(mk(0, 32'h600, 32'h0));
        tick();
        set_p1(0, 0, 0, 0);
        set_p0(1, 1, 32'h700, 32'hDEAD_BEEF);
        exp_mem.push_back(mk(1, 32'h700, 32'hDEAD_BEEF));
        tick();
        set_p0(0, 0, 0, 0);
        tick();
        respond(64'hC0C0_0000_0000_0001, 0);
        respond(64'hC1C1_0000_0000_0002, 1);
        #1;
        check("t4_no_tag_for_write", bus.oMEM_LOCK, 1);

        // Output register back-pressure.
        bus.iMEM_LOCK = 1'b1;
        set_p0(1, 1, 32'h900, 32'h9);
        exp_mem.push_back(mk(1, 32'h900, 32'h9));
        tick();
        set_p0(1, 1, 32'h904, 32'hA);
        exp_mem.push_back(mk(1, 32'h904, 32'hA));
        #1;
        check("t5_reg_full_lock", bus.oP0_LOCK, 1);
        check("t5_reg_held", bus.oMEM_ADDR, 32'h900);
        bus.iMEM_LOCK = 1'b0;
        #1;
        check("t5_retire_accept", bus.oP0_LOCK, 0);
        tick();
        set_p0(0, 0, 0, 0);
        tick();

        // Head owner P1 locked.
        set_p1(1, 0, 32'h800, 32'h0);
        exp_mem.push_back(mk(0, 32'h800, 32'h0));
        tick();
        set_p1(0, 0, 0, 0);
        tick();
        bus.iP1_LOCK = 1'b1;
        #1;
        check("t6_mem_lock_p1", bus.oMEM_LOCK, 1);
        bus.iP1_LOCK = 1'b0;
        bus.iP0_LOCK = 1'b1;
        #1;
        check("t6_mem_lock_released", bus.oMEM_LOCK, 0);
        bus.iP0_LOCK = 1'b0;
        respond(64'hD00D_0000_0000_0003, 1);

        // Spurious response: sticky error.
        #1;
        check("t7_err_clear", oERR, 0);
        bus.iMEM_VALID = 1'b1;
        bus.iMEM_DATA  = 64'hEEEE;
        #1;
        check("t7_no_valid", {bus.oP0_VALID, bus.oP1_VALID}, 0);
        tick();
        bus.iMEM_VALID = 1'b0;
        check("t7_err_set", oERR, 1);
        repeat (3) tick();
        check("t7_err_sticky", oERR, 1);
        do_reset();
        check("t7_err_reset", oERR, 0);

        tick();
        check("end_mem_queue", 128'(exp_mem.size()), 0);
        check("end_rsp_queue", 128'(exp_rsp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sim_memory_arbiter.md
SIM_MEMORY_ARBITER -- requirements
Module: sim_memory_arbiter

Interface
REQ-001 SHALL have parameter P_TAG_DEPTH, default 8, meaning maximum number of outstanding reads (equal to the memory model output FIFO depth).
REQ-002 SHALL have parameter P_TAG_DEPTH_N, default 3, meaning log2 of P_TAG_DEPTH.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port iCLOCK, input, 1 bit: the clock.
REQ-005 SHALL have port iRESET_SYNC, input, 1 bit: the synchronous, active-high reset.
REQ-006 SHALL have, for each requester n in {0,1}, the inputs iPn_REQ (1), iPn_ORDER (2), iPn_MASK (4), iPn_RW (1, 1=write), iPn_ADDR (32), iPn_DATA (32) and iPn_LOCK (1, requester cannot take a response).
REQ-007 SHALL have, for each requester n in {0,1}, the outputs oPn_LOCK (1, request not accepted), oPn_VALID (1) and oPn_DATA (64).
REQ-008 SHALL have the memory-side outputs oMEM_REQ (1), oMEM_ORDER (2), oMEM_MASK (4), oMEM_RW (1), oMEM_ADDR (32), oMEM_DATA (32) and oMEM_LOCK (1).
REQ-009 SHALL have the memory-side inputs iMEM_LOCK (1), iMEM_VALID (1) and iMEM_DATA (64).
REQ-010 SHALL have port oERR, output, 1 bit: sticky protocol-error flag.

Function
REQ-011 SHALL accept a request from port n in a cycle when iPn_REQ=1 and oPn_LOCK=0; a requester holds its request fields stable while oPn_LOCK=1.
REQ-012 SHALL hold the accepted request in a single output register; oMEM_REQ=1 while the register is full.
REQ-013 SHALL retire the output register when oMEM_REQ=1 and iMEM_LOCK=0.
REQ-014 SHALL treat the output register as able to take a request when it is empty or retiring in that cycle.
REQ-015 SHALL give an accept-to-oMEM_REQ latency of exactly 1 cycle, with back-to-back accepts sustained at 1 per cycle while iMEM_LOCK=0.
REQ-016 SHALL allow port n to be granted only if the output register can take a request and, when iPn_RW=0, the tag count is below P_TAG_DEPTH; the count used is the value before any pop in that cycle.
REQ-017 SHALL arbitrate round-robin: when both ports are eligible, grant the port not granted last; when one port is eligible, grant it.
REQ-018 SHALL assert oPn_LOCK=1 whenever port n is not granted.
REQ-019 SHALL push the requester ID into a tag FIFO when it accepts a read; writes SHALL NOT push a tag.
REQ-020 SHALL route a response to the tag head: oPn_VALID = iMEM_VALID && tag non-empty && head==n, combinationally, with oP0_DATA=oP1_DATA=iMEM_DATA.
REQ-021 SHALL pop the tag FIFO whenever iMEM_VALID=1.
REQ-022 SHALL drive oMEM_LOCK = iPh_LOCK for head owner h when the tag FIFO is non-empty, and 1 when it is empty.
REQ-023 SHALL allow a push and a pop in the same cycle, leaving the tag count unchanged.
REQ-024 SHALL set oERR=1 when iMEM_VALID=1 with the tag FIFO empty, or when a read is accepted while the tag count is P_TAG_DEPTH; oERR SHALL stay set until reset.

Reset
REQ-025 SHALL on iRESET_SYNC reset the output register to empty (oMEM_REQ=0), all oMEM_* fields to 0, the tag FIFO to empty (count 0), the last-grant pointer to port 1 (so port 0 wins first) and oERR to 0.
REQ-026 SHALL drive oPn_LOCK=1 and oPn_VALID=0 during reset.
REQ-027 SHALL on a reset mid-operation discard in-flight requests and tags; flushing the memory model is the system's responsibility.

Configuration
REQ-028 SHALL, when macro SIM_MEMORY_ARBITER_FIXED_PRIORITY_EN is defined, always grant port 0 over port 1 and leave the last-grant pointer unused.
REQ-029 SHALL, when SIM_MEMORY_ARBITER_FIXED_PRIORITY_EN is undefined, use round-robin arbitration per REQ-017.

Structure
REQ-030 SHALL place the requester-ID width, P_TAG_DEPTH and P_TAG_DEPTH_N defaults, and the ORDER encoding constants (00 byte, 01 half-word, 10 word, 11 none) in shared package sim_memory_pkg.
REQ-031 SHALL implement the tag FIFO as sub-module sim_memory_arbiter_tag_fifo: 1-bit data, depth P_TAG_DEPTH, with count, full and empty outputs.

Verification
REQ-032 SHALL verify: P0 read of 0x100 alone -> oMEM_REQ next cycle with ADDR=0x100; data returned only on oP0_VALID.
REQ-033 SHALL verify: both ports requesting every cycle -> grants alternate P0,P1,P0,P1; with the macro defined -> P0 every cycle and P1 locked.
REQ-034 SHALL verify: iMEM_LOCK=0 with the responder holding valid off, P0 issues 9 reads -> 8 accepted, the 9th stays locked until the first response pops.
REQ-035 SHALL verify: P0 read, then P1 read, then P0 write -> responses arrive in order on P0 then P1; the write produces no response.
REQ-036 SHALL verify: head owner P1 with iP1_LOCK=1 -> oMEM_LOCK=1 and no valid; releasing iP1_LOCK -> oP1_VALID.
REQ-037 SHALL verify: iMEM_VALID pulsed with no outstanding reads -> oERR=1 and held until iRESET_SYNC.
